// File: rtl/mem_pkg.sv
// Shared memory-stage encodings: access widths,
// exception codes and data-cache FSM states.
package mem_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b10;
  localparam logic [1:0] W_WORD = 2'b11;

  localparam logic [6:0] EXP_NONE = 7'h00;
  localparam logic [6:0] EXP_ALE  = 7'h09;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Width 01 is handled like a word.
  function automatic logic misaligned(
    input logic [1:0] width,
    input logic [1:0] lane
  );
    logic m;
    m = (lane != 2'b00);
    if (width == W_BYTE) m = 1'b0;
    if (width == W_HALF) m = lane[0];
    return m;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Load lane select plus sign/zero extension.
// i_width/i_lane/i_signed/i_rdata in, o_data out.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [1:0]  i_width,
  input  logic [1:0]  i_lane,
  input  logic        i_signed,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;
  logic        w_sb;
  logic        w_sh16;

  assign w_sh   = i_rdata >> {i_lane, 3'b000};
  assign w_sb   = i_signed & w_sh[7];
  assign w_sh16 = i_signed & w_sh[15];

  always_comb begin
    o_data = i_rdata;
    unique case (i_width)
      W_BYTE:  o_data = {{24{w_sb}}, w_sh[7:0]};
      W_HALF:  o_data = {{16{w_sh16}}, w_sh[15:0]};
      W_WORD:  o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dcache_req_ctrl.sv
// Memory-stage data-cache port sequencer.
// req_* in, cache valid/op/addr/data out, resp_* back.
module dcache_req_ctrl
  import mem_pkg::*;
#(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_width,
  input  logic                req_signed,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [4:0]          req_rd,
  input  logic [6:0]          req_exp,
  input  logic                flush,
  output logic                valid,
  output logic                op,
  output logic [TAG_W-1:0]    tag,
  output logic [INDEX_W-1:0]  index,
  output logic [OFFSET_W-1:0] offset,
  output logic [3:0]          write_type,
  output logic [31:0]         w_data_CPU,
  input  logic                addr_valid,
  input  logic                data_valid,
  input  logic [31:0]         r_data_CPU,
  output logic                resp_valid,
  output logic [4:0]          resp_rd,
  output logic [31:0]         resp_data,
  output logic [6:0]          resp_exp,
  output logic                stall_because_cache
);

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic        r_write;
  logic [1:0]  r_width;
  logic        r_signed;
  logic [4:0]  r_rd;
  logic [3:0]  r_wt;
  logic [31:0] r_wd;
  logic        r_drop;
  logic        r_rv;
  logic [4:0]  r_rrd;
  logic [31:0] r_rdata;
  logic [6:0]  r_rexp;

  logic        w_acc, w_bad, w_go, w_err;
  logic        w_done, w_drop;
  logic [3:0]  w_wt;
  logic [31:0] w_wd, w_ld;

  assign w_acc = req_valid & (r_state == S_IDLE);
  assign w_bad = (req_exp != EXP_NONE)
               | misaligned(req_width, req_addr[1:0]);
  assign w_go  = w_acc & ~flush & ~w_bad;
  assign w_err = w_acc & ~flush & w_bad;

  assign w_done = (r_state == S_REQ & addr_valid & data_valid)
                | (r_state == S_WAIT & data_valid);
  // A flush in the completing cycle also drops the result.
  assign w_drop = r_drop | flush;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_go) w_next = S_REQ;
      S_REQ:   if (addr_valid)
                 w_next = data_valid ? S_IDLE : S_WAIT;
      S_WAIT:  if (data_valid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wt = 4'b1111;
    w_wd = req_wdata;
    unique case (req_width)
      W_BYTE: begin
        w_wt = 4'b0001 << req_addr[1:0];
        w_wd = {4{req_wdata[7:0]}};
      end
      W_HALF: begin
        w_wt = 4'b0011 << req_addr[1:0];
        w_wd = {2{req_wdata[15:0]}};
      end
      default: w_wt = 4'b1111;
    endcase
    if (!req_write) w_wt = 4'b0000;
  end

  load_align_ext u_ext (
    .i_width  (r_width),
    .i_lane   (r_addr[1:0]),
    .i_signed (r_signed),
    .i_rdata  (r_data_CPU),
    .o_data   (w_ld)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_width  <= '0;
      r_signed <= 1'b0;
      r_rd     <= '0;
      r_wt     <= '0;
      r_wd     <= '0;
      r_drop   <= 1'b0;
      r_rv     <= 1'b0;
      r_rrd    <= '0;
      r_rdata  <= '0;
      r_rexp   <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_addr   <= req_addr;
        r_write  <= req_write;
        r_width  <= req_width;
        r_signed <= req_signed;
        r_rd     <= req_rd;
        r_wt     <= w_wt;
        r_wd     <= w_wd;
        r_drop   <= 1'b0;
      end else if (r_state != S_IDLE && flush) begin
        r_drop <= 1'b1;
      end
      r_rv    <= 1'b0;
      r_rrd   <= '0;
      r_rdata <= '0;
      r_rexp  <= '0;
      if (w_err) begin
        r_rv   <= 1'b1;
        r_rrd  <= req_write ? 5'd0 : req_rd;
        r_rexp <= (req_exp != EXP_NONE) ? req_exp : EXP_ALE;
      end
      if (w_done && !w_drop) begin
        r_rv    <= 1'b1;
        r_rrd   <= r_write ? 5'd0 : r_rd;
        r_rdata <= r_write ? 32'd0 : w_ld;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign valid      = (r_state == S_REQ);
  assign op         = r_write;
  assign tag        = r_addr[31 -: TAG_W];
  assign index      = r_addr[OFFSET_W +: INDEX_W];
  assign offset     = r_addr[OFFSET_W-1:0];
  assign write_type = r_wt;
  assign w_data_CPU = r_wd;
  assign resp_valid = r_rv;
  assign resp_rd    = r_rrd;
  assign resp_data  = r_rdata;
  assign resp_exp   = r_rexp;
  assign stall_because_cache = (r_state != S_IDLE);

endmodule
